pcss_spk_framer: RTL
====================

Name: pcss_spk_framer

Overview:
- Sits directly downstream of pcss_inf on the receive path; consumes its 64-bit AXI-stream of output spike words (M_AXIS_recv_*).
- Buffers the words and repackages them into one AXI-stream frame per tik period for the host DMA.
- Each frame is a header word (tik number, word count, flags) followed by the buffered spike words; tlast marks the frame end.

Parameters:
- DATA_WIDTH, 64, stream word width; fixed at 64 because the header layout depends on it.
- DEPTH, 256, spike FIFO depth in words; power of two, maximum 32768.
- AW, log2(DEPTH), FIFO address width.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; synchronous, active-low.
- tik  input  1  tik pulse from pcss_inf; a falling edge closes the current frame.
- S_AXIS_spk_tdata  input  64  spike word from pcss_inf.
- S_AXIS_spk_tvalid  input  1  spike word valid.
- S_AXIS_spk_tready  output  1  framer can accept a spike word.
- M_AXIS_frm_tdata  output  64  frame word to host.
- M_AXIS_frm_tvalid  output  1  frame word valid.
- M_AXIS_frm_tlast  output  1  last word of frame.
- M_AXIS_frm_tkeep  output  8  byte enables; constant 8'hFF.
- M_AXIS_frm_tready  input  1  host accepts a frame word.
- busy  output  1  frame emitter not in IDLE, or pending slot full.

Behaviour:
- Reset (rst_n=0 at posedge clk) gives these values:
  - S_AXIS_spk_tready=0 for the reset cycle, then per rule below.
  - M_AXIS_frm_tvalid=0, M_AXIS_frm_tlast=0, M_AXIS_frm_tdata=0, busy=0.
  - FIFO empty, open_cnt=0, tik_num=0, tik_dly=0, pending slot empty, sticky flags cleared.
  - Reset mid-frame abandons the frame; no partial output follows.
- Accept: a word is accepted on a cycle where tvalid and tready are both high. It is written to the FIFO and open_cnt increments.
- Close detection:
  - tik_dly is tik registered; close_evt = tik_dly & ~tik.
  - Close takes effect one cycle after tik falls.
  - A word accepted in the close_evt cycle belongs to the next frame.
- On close_evt with the pending slot empty:
  - Load pending = {tik_num, len=open_cnt, ovf_sticky, merged_sticky}.
  - Clear open_cnt, ovf_sticky and merged_sticky.
  - tik_num increments by 1 and wraps at 16 bits.
- On close_evt with the pending slot full:
  - The frame is not closed. open_cnt continues counting, merged_sticky=1, tik_num still increments.
  - The next successful close reports the merged length and the latest tik_num-1 as the frame's tik number.
- Header word layout:
  - [63:56]=8'hA5, [55]=ovf, [54]=merged, [53:48]=0.
  - [47:32]=tik number, [31:16]=len, [15:0]=16'h0000.
  - A header therefore can never equal all-ones (the host end marker).
- Emitter FSM:
  - IDLE: when the pending slot is full, go to HDR.
  - HDR: drive header, tvalid=1, tlast=(len==0). On handshake: go to IDLE and free the slot if len==0, else go to BODY with remaining=len.
  - BODY: drive the FIFO head word, tvalid=1, tlast=(remaining==1). On handshake: pop and decrement remaining. When remaining reaches 0, go to IDLE and free the slot.
  - The slot becomes free in the same cycle as the final handshake. A close_evt in that same cycle loads the slot (free wins).
- AXI output rules:
  - Once tvalid=1, tdata, tlast and tvalid hold until the handshake.
  - The FIFO read has zero added latency (first-word-fall-through).
  - With continuous tready, back-to-back frames cost exactly 1 idle cycle between a frame's last word and the next header.
- FIFO full/empty:
  - BODY never sees an empty FIFO, because len counts only words already written.
  - Full handling depends on the optional feature.

Optional Feature:
- Macro: PCSS_FRAMER_DROP_EN.
- Defined:
  - S_AXIS_spk_tready=1 at all times after reset.
  - A word arriving while the FIFO is full is discarded, is not counted in open_cnt, and sets ovf_sticky.
- Undefined:
  - S_AXIS_spk_tready = ~fifo_full, giving backpressure into pcss_inf.
  - ovf is always 0.

Test Plan:
- 3 spike words 0x11,0x22,0x33, then tik high 1 cycle then low, tready=1 -> header 0xA500_0000_0003_0000, words 0x11,0x22,0x33, tlast on 0x33.
- Two tik pulses with no spikes -> headers 0xA500_0000_0000_0000 then 0xA500_0001_0000_0000, each with tlast=1.
- Hold M_AXIS_frm_tready=0 during frame 0, send 2 words and close frame 1, then a third tik -> frame 1 merged; its header has bit54=1, len=2 plus later words, tik number 2.
- DEPTH=4, send 6 words without output draining: DROP_EN -> header len=4, bit55=1; no DROP_EN -> tready low after 4 words, last 2 accepted later into the next frame.
- Word accepted in the exact close_evt cycle -> counted in the next frame's len, not the current one.
- Assert rst_n=0 while in BODY -> next cycle tvalid=0; a new close yields a header with tik number 0.

Source files
------------

// File: rtl/pcss_spk_framer.sv
// Spike framer: buffers pcss_inf spike words and emits one header+body AXI-stream frame per tik period.
// Optional PCSS_FRAMER_DROP_EN: never backpressure; drop words on a full FIFO and report ovf in the header.
module pcss_spk_framer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tik,
  input  logic [DATA_WIDTH-1:0] S_AXIS_spk_tdata,
  input  logic                  S_AXIS_spk_tvalid,
  output logic                  S_AXIS_spk_tready,
  output logic [DATA_WIDTH-1:0] M_AXIS_frm_tdata,
  output logic                  M_AXIS_frm_tvalid,
  output logic                  M_AXIS_frm_tlast,
  output logic [7:0]            M_AXIS_frm_tkeep,
  input  logic                  M_AXIS_frm_tready,
  output logic                  busy
);
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR = 2'd1, S_BODY = 2'd2} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q, count_d;
  logic [CW-1:0]         open_cnt_q, open_cnt_d;
  logic [CW-1:0]         tik_num_q, tik_num_d;
  logic [CW-1:0]         rem_q, rem_d;
  logic                  ovf_q, ovf_d, mrg_q, mrg_d;
  logic                  pend_full_q, pend_full_d;
  logic [CW-1:0]         pend_tik_q, pend_tik_d, pend_len_q, pend_len_d;
  logic                  pend_ovf_q, pend_ovf_d, pend_mrg_q, pend_mrg_d;
  logic                  tik_dly_q, rst_done_q;

  logic fifo_full, accept, wr_en, drop, pop, frm_hs, pend_free, close_evt, load, merge;

  assign fifo_full = (count_q == (AW+1)'(DEPTH));
  assign accept    = S_AXIS_spk_tvalid & S_AXIS_spk_tready;
  assign close_evt = tik_dly_q & ~tik;

`ifdef PCSS_FRAMER_DROP_EN
  assign S_AXIS_spk_tready = rst_done_q;
  assign wr_en             = accept & ~fifo_full;
  assign drop              = accept & fifo_full;
`else
  assign S_AXIS_spk_tready = rst_done_q & ~fifo_full;
  assign wr_en             = accept;
  assign drop              = 1'b0;
`endif

  assign frm_hs    = M_AXIS_frm_tvalid & M_AXIS_frm_tready;
  assign pop       = frm_hs & (state_q == S_BODY);
  assign pend_free = frm_hs & (((state_q == S_HDR) & (pend_len_q == '0)) |
                               ((state_q == S_BODY) & (rem_q == CW'(1))));
  // A slot freed by this cycle's final handshake can take the closing frame at once.
  assign load      = close_evt & (~pend_full_q | pend_free);
  assign merge     = close_evt & ~load;

  assign M_AXIS_frm_tkeep = 8'hFF;
  assign busy             = (state_q != S_IDLE) | pend_full_q;

  // Emitter state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Emitter next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (pend_full_q) state_d = S_HDR;
      S_HDR:  if (frm_hs) state_d = (pend_len_q == '0) ? S_IDLE : S_BODY;
      S_BODY: if (frm_hs && rem_q == CW'(1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Emitter outputs; FIFO head is presented directly (first-word-fall-through)
  always_comb begin
    M_AXIS_frm_tvalid = 1'b0;
    M_AXIS_frm_tlast  = 1'b0;
    M_AXIS_frm_tdata  = '0;
    case (state_q)
      S_HDR: begin
        M_AXIS_frm_tvalid = 1'b1;
        M_AXIS_frm_tlast  = (pend_len_q == '0);
        M_AXIS_frm_tdata  = {8'hA5, pend_ovf_q, pend_mrg_q, 6'd0, pend_tik_q, pend_len_q, 16'h0000};
      end
      S_BODY: begin
        M_AXIS_frm_tvalid = 1'b1;
        M_AXIS_frm_tlast  = (rem_q == CW'(1));
        M_AXIS_frm_tdata  = mem[rd_ptr_q];
      end
      default: ;
    endcase
  end

  // Frame accounting and pending-slot next state
  always_comb begin
    count_d     = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    open_cnt_d  = open_cnt_q + CW'(wr_en);
    ovf_d       = ovf_q | drop;
    mrg_d       = mrg_q;
    tik_num_d   = tik_num_q;
    pend_full_d = pend_full_q & ~pend_free;
    pend_tik_d  = pend_tik_q;
    pend_len_d  = pend_len_q;
    pend_ovf_d  = pend_ovf_q;
    pend_mrg_d  = pend_mrg_q;
    rem_d       = rem_q;
    if (close_evt) tik_num_d = tik_num_q + CW'(1);
    if (load) begin
      pend_full_d = 1'b1;
      pend_tik_d  = tik_num_q;
      pend_len_d  = open_cnt_q;
      pend_ovf_d  = ovf_q;
      pend_mrg_d  = mrg_q;
      open_cnt_d  = CW'(wr_en);
      ovf_d       = drop;
      mrg_d       = 1'b0;
    end else if (merge) begin
      mrg_d = 1'b1;
    end
    if (frm_hs && state_q == S_HDR) rem_d = pend_len_q;
    else if (pop)                   rem_d = rem_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= S_AXIS_spk_tdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      open_cnt_q  <= '0;
      tik_num_q   <= '0;
      rem_q       <= '0;
      ovf_q       <= 1'b0;
      mrg_q       <= 1'b0;
      pend_full_q <= 1'b0;
      pend_tik_q  <= '0;
      pend_len_q  <= '0;
      pend_ovf_q  <= 1'b0;
      pend_mrg_q  <= 1'b0;
      tik_dly_q   <= 1'b0;
      rst_done_q  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q     <= count_d;
      open_cnt_q  <= open_cnt_d;
      tik_num_q   <= tik_num_d;
      rem_q       <= rem_d;
      ovf_q       <= ovf_d;
      mrg_q       <= mrg_d;
      pend_full_q <= pend_full_d;
      pend_tik_q  <= pend_tik_d;
      pend_len_q  <= pend_len_d;
      pend_ovf_q  <= pend_ovf_d;
      pend_mrg_q  <= pend_mrg_d;
      tik_dly_q   <= tik;
      rst_done_q  <= 1'b1;
    end
  end

endmodule
